hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage pipeline. Tracks in-flight destination
//  registers of instructions in EX..WB, stalls decode on unresolvable dependencies (load-use, or any
//  RAW when forwarding is disabled), and drives EX operand-forwarding selects. Sits beside decode_stage,
//  and its outputs feed the PC/D-register enables, the EX bubble insert and the EX operand muxes.
// PARAMETERS
//  REG_ADDR_W  5  register address width; address 0 is hard-wired zero, never a hazard source
//  N_STAGES    3  tracked stages after decode: 0=EX, 1=MEM, 2=WB (>=2)
//  LOAD_STAGE  2  first stage index whose output carries load data (stage index, <=N_STAGES)
//  FWD_EN      1  1: forward from stages 1..N_STAGES-1; 0: no forwarding, wait for regfile write
//  CNT_W       16 performance counter width
// PORTS
//  SYS_clk      in   1           pipeline clock; state updates on falling edge, as the pipeline registers do
//  SYS_reset    in   1           reset, asynchronous, active-high
//  D_valid      in   1           decode holds a real instruction
//  D_rs, D_rt   in   REG_ADDR_W  decode source registers
//  D_use_rs     in   1           decode instruction reads rs
//  D_use_rt     in   1           decode instruction reads rt (R-type, store, branch)
//  D_dst        in   REG_ADDR_W  decode destination (already muxed rd/rt)
//  D_reg_write  in   1           decode instruction writes a register
//  D_mem_read   in   1           decode instruction is a load
//  D_flush      in   1           kill decode instruction (branch taken/redirect)
//  D_stall      out  1           hold PC and D register this cycle
//  EX_bubble    out  1           EX register loads a NOP on the next edge (= D_stall | D_flush | !D_valid)
//  fwd_sel_a/b  out  clog2(N_STAGES)  EX operand source: 0=regfile value, k=result of stage k
//  stall_cnt    out  CNT_W       number of cycles with D_stall=1, saturating
//  fwd_cnt      out  CNT_W       number of cycles with any fwd_sel!=0, saturating
// BEHAVIOUR
//  Entry e[s], s=0..N_STAGES-1: {valid, dst, reg_write, mem_read}, for the instruction in stage s.
//  live(s,r) = e[s].valid & e[s].reg_write & e[s].dst==r & r!=0.
//  avail(s) = N_STAGES if FWD_EN=0; else LOAD_STAGE if e[s].mem_read; else 1.
//  D_stall (comb) = D_valid & !D_flush & exists s, r in used sources: live(s,r) & (s+1 < avail(s)).
//  Falling edge, no reset: e[k] <= e[k-1] for k>=1 (always; the pipeline never freezes past D);
//   e[0] <= EX_bubble ? invalid : {1, D_dst, D_reg_write, D_mem_read}.
//  D_flush has priority over the stall: the instruction is killed, D_stall=0, a bubble enters EX.
//  fwd_sel_a (comb, FWD_EN=1): smallest k in 1..N_STAGES-1 with live(k, EX rs), else 0. The youngest
//   producer wins. The EX source registers are captured in internal regs alongside e[0]. fwd_sel_b is
//   the same for rt. With FWD_EN=0 both are constant 0.
//  A producer in stage N_STAGES-1 that coincides with the consumer in D relies on the regfile
//   write-through bypass: that is a regfile requirement and outside this block.
//  Counters increment by 1 per falling edge when their condition holds; they hold at 2^CNT_W-1.
//  Reset (asynchronous, any time, including mid-stall): all e[] invalid, EX sources 0, counters 0. As a
//   result D_stall=0 and fwd_sel=0 while reset is held. EX_bubble follows its equation.
//  Load-use, default parameters: exactly 1 stall cycle, then fwd_sel=2 (load data from WB).
// STRUCTURE
//  hazard_defs.vh: FWD_REGFILE=0 and entry field offsets/width localparams, shared with the
//   decode_stage and execution_stage muxes.
//  Sub-module hazard_match: combinational {valid, reg_write, dst, r}, returns a hit with the r!=0 guard.
//   It is instantiated per stage and per source by generate loops.
//  The top holds the entry shift register, the stall/forward priority logic and the counters.
// TESTING
//  add r1,r2,r3; add r4,r1,r1 -> D_stall never 1; with the 2nd add in EX, fwd_sel_a=fwd_sel_b=1.
//  lw r3,0(r0); add r4,r3,r0 -> D_stall=1 for exactly 1 cycle, EX_bubble=1; add in EX has fwd_sel_a=2; stall_cnt=1.
//  add r0,r1,r2; add r5,r0,r0 -> no stall, fwd_sel=0 (r0 never matches).
//  lw r3; add r4,r3 with D_flush=1 in the stall cycle -> D_stall=0, bubble enters EX, no fwd afterwards.
//  FWD_EN=0: add r1; add r2,r1 -> D_stall=1 for 2 cycles, then consumer in EX with fwd_sel=0.
//  Assert SYS_reset between edges during a load-use stall -> D_stall=0 immediately, counters 0, entries clear.
//  Force 2^CNT_W+5 stall cycles (CNT_W=4 build) -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared hazard entry layout and sizing helpers
package hazard_scoreboard_pkg;

  localparam int FWD_REGFILE = 0;

  // Entry bit layout: {dst, mem_read, reg_write, valid}
  localparam int ENT_VALID = 0;
  localparam int ENT_RW    = 1;
  localparam int ENT_MR    = 2;
  localparam int ENT_DST   = 3;

  function automatic int ent_w(input int addr_w);
    return ENT_DST + addr_w;
  endfunction

  function automatic int sel_w(input int n_stages);
    return (n_stages > 2) ? $clog2(n_stages) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side hazard request and forwarding select bundle
interface hazard_scoreboard_if import hazard_scoreboard_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int N_STAGES   = 3
) ();

  localparam int SEL_W = sel_w(N_STAGES);

  logic                  D_valid;
  logic [REG_ADDR_W-1:0] D_rs;
  logic [REG_ADDR_W-1:0] D_rt;
  logic                  D_use_rs;
  logic                  D_use_rt;
  logic [REG_ADDR_W-1:0] D_dst;
  logic                  D_reg_write;
  logic                  D_mem_read;
  logic                  D_flush;
  logic                  D_stall;
  logic                  EX_bubble;
  logic [SEL_W-1:0]      fwd_sel_a;
  logic [SEL_W-1:0]      fwd_sel_b;

  modport master (
    output D_valid, D_rs, D_rt, D_use_rs, D_use_rt, D_dst, D_reg_write, D_mem_read, D_flush,
    input  D_stall, EX_bubble, fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  D_valid, D_rs, D_rt, D_use_rs, D_use_rt, D_dst, D_reg_write, D_mem_read, D_flush,
    output D_stall, EX_bubble, fwd_sel_a, fwd_sel_b
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// rtl/hazard_scoreboard_match.sv - one in-flight producer vs one source register compare
module hazard_match #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  valid,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] dst,
  input  logic [REG_ADDR_W-1:0] r,
  output logic                  hit
);

  // r0 is hard-wired zero, so it can never carry a dependency
  assign hit = valid & reg_write & (dst == r) & (r != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker, decode stall and EX forwarding selects
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int N_STAGES   = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  hazard_scoreboard_if.slave dif,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  localparam int EW = ent_w(REG_ADDR_W);
  localparam int SW = sel_w(N_STAGES);

  logic [N_STAGES-1:0][EW-1:0] ent_q, ent_d;
  logic [REG_ADDR_W-1:0]       ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [N_STAGES-1:0]         hit_d_rs, hit_d_rt;
  logic [N_STAGES-1:1]         hit_ex_rs, hit_ex_rt;
  logic                        raw_block;
  logic [SW-1:0]               sel_a, sel_b;

  for (genvar s = 0; s < N_STAGES; s++) begin : g_dec
    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_rs (
      .valid(ent_q[s][ENT_VALID]), .reg_write(ent_q[s][ENT_RW]),
      .dst(ent_q[s][ENT_DST +: REG_ADDR_W]), .r(dif.D_rs), .hit(hit_d_rs[s]));
    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_rt (
      .valid(ent_q[s][ENT_VALID]), .reg_write(ent_q[s][ENT_RW]),
      .dst(ent_q[s][ENT_DST +: REG_ADDR_W]), .r(dif.D_rt), .hit(hit_d_rt[s]));
  end

  for (genvar k = 1; k < N_STAGES; k++) begin : g_ex
    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_rs (
      .valid(ent_q[k][ENT_VALID]), .reg_write(ent_q[k][ENT_RW]),
      .dst(ent_q[k][ENT_DST +: REG_ADDR_W]), .r(ex_rs_q), .hit(hit_ex_rs[k]));
    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_rt (
      .valid(ent_q[k][ENT_VALID]), .reg_write(ent_q[k][ENT_RW]),
      .dst(ent_q[k][ENT_DST +: REG_ADDR_W]), .r(ex_rt_q), .hit(hit_ex_rt[k]));
  end

  // First stage whose output can feed a consumer sitting in EX
  function automatic int avail(input logic mem_read);
    if (FWD_EN == 0) return N_STAGES;
    return mem_read ? LOAD_STAGE : 1;
  endfunction

  always_comb begin
    raw_block = 1'b0;
    for (int s = 0; s < N_STAGES; s++) begin
      if (((hit_d_rs[s] && dif.D_use_rs) || (hit_d_rt[s] && dif.D_use_rt)) &&
          (s + 1 < avail(ent_q[s][ENT_MR])))
        raw_block = 1'b1;
    end
  end

  assign dif.D_stall   = dif.D_valid & ~dif.D_flush & raw_block;
  assign dif.EX_bubble = dif.D_stall | dif.D_flush | ~dif.D_valid;

  // Descending scan so the youngest producer overrides older ones
  always_comb begin
    sel_a = SW'(FWD_REGFILE);
    sel_b = SW'(FWD_REGFILE);
    if (FWD_EN != 0) begin
      for (int k = N_STAGES - 1; k >= 1; k--) begin
        if (hit_ex_rs[k]) sel_a = SW'(k);
        if (hit_ex_rt[k]) sel_b = SW'(k);
      end
    end
  end

  assign dif.fwd_sel_a = sel_a;
  assign dif.fwd_sel_b = sel_b;

  always_comb begin
    ent_d   = '0;
    ex_rs_d = '0;
    ex_rt_d = '0;
    for (int k = 1; k < N_STAGES; k++) ent_d[k] = ent_q[k-1];
    if (!dif.EX_bubble) begin
      ent_d[0][ENT_VALID]               = 1'b1;
      ent_d[0][ENT_RW]                  = dif.D_reg_write;
      ent_d[0][ENT_MR]                  = dif.D_mem_read;
      ent_d[0][ENT_DST +: REG_ADDR_W]   = dif.D_dst;
      ex_rs_d                           = dif.D_rs;
      ex_rt_d                           = dif.D_rt;
    end
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (dif.D_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (((sel_a != '0) || (sel_b != '0)) && (fwd_cnt_q != {CNT_W{1'b1}}))
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
  end

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      ent_q       <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      ent_q       <= ent_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule
